// File: rtl/display_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : display_scan_ctrl_if
// Brief    : Display-word write channel (valid/ready) into the scan controller.
// Revision : 1.0 - initial release
// ============================================================================
interface display_scan_ctrl_if #(
  parameter int NUM_DIGITS = 8
) ();

  logic                    valid;
  logic [4*NUM_DIGITS-1:0] data;
  logic                    ready;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );

endinterface
`default_nettype wire

// File: rtl/display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : display_scan_ctrl
// Brief    : Multiplexed 7-segment scan with dead-time guard and frame-aligned
//            display-word updates.
// Revision : 1.0 - initial release
// ============================================================================
module display_scan_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int DIGIT_CYC  = 50000,
  parameter int GUARD_CYC  = 500
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  lzb,
  display_scan_ctrl_if.slave    wr,
  output logic [3:0]            hex,
  output logic                  blank,
  output logic [NUM_DIGITS-1:0] dig_sel,
  output logic                  frame_done
);

  localparam int CNT_MAX = (DIGIT_CYC > GUARD_CYC) ? DIGIT_CYC : GUARD_CYC;
  localparam int CW      = $clog2(CNT_MAX);
  localparam int IW      = $clog2(NUM_DIGITS);

  localparam logic [CW-1:0] C_DIG_LAST = CW'(DIGIT_CYC - 1);
  localparam logic [CW-1:0] C_GRD_LAST = CW'(GUARD_CYC - 1);
  localparam logic [IW-1:0] C_IDX_LAST = IW'(NUM_DIGITS - 1);

  typedef enum logic [0:0] {
    ST_GUARD = 1'b0,
    ST_SCAN  = 1'b1
  } state_t;

  state_t                       r_state, w_state_n;
  logic [CW-1:0]                r_cnt, w_cnt_n;
  logic [IW-1:0]                r_idx, w_idx_n;
  logic [NUM_DIGITS-1:0][3:0]   r_active, w_active_n;
  logic [NUM_DIGITS-1:0][3:0]   r_pending, w_pending_n;
  logic                         r_wr_ready, w_wr_ready_n;
  logic [3:0]                   w_hex_n;
  logic                         w_blank_n;
  logic [NUM_DIGITS-1:0]        w_dig_sel_n;
  logic                         w_frame_done_n;
  logic                         w_accept;

  assign w_accept = wr.valid && r_wr_ready;
  assign wr.ready = r_wr_ready;

  // Outputs are registered from the next-state values so they line up with
  // the state register rather than trailing it by a cycle.
  always_comb begin
    w_state_n      = r_state;
    w_cnt_n        = r_cnt;
    w_idx_n        = r_idx;
    w_active_n     = r_active;
    w_pending_n    = r_pending;
    w_wr_ready_n   = r_wr_ready;
    w_frame_done_n = 1'b0;
    w_hex_n        = hex;
    w_blank_n      = 1'b1;
    w_dig_sel_n    = '1;

    if (w_accept) begin
      w_pending_n  = wr.data;
      w_wr_ready_n = 1'b0;
    end

    if (en) begin
      case (r_state)
        ST_GUARD: begin
          if (r_cnt == C_GRD_LAST) begin
            w_state_n = ST_SCAN;
            w_cnt_n   = '0;
          end else begin
            w_cnt_n = r_cnt + CW'(1);
          end
        end
        ST_SCAN: begin
          if (r_cnt == C_DIG_LAST) begin
            w_state_n = ST_GUARD;
            w_cnt_n   = '0;
            if (r_idx == C_IDX_LAST) begin
              w_idx_n        = '0;
              w_frame_done_n = 1'b1;
              // A full pending buffer cannot coincide with a new accept.
              if (!r_wr_ready) begin
                w_active_n   = r_pending;
                w_wr_ready_n = 1'b1;
              end
            end else begin
              w_idx_n = r_idx + IW'(1);
            end
          end else begin
            w_cnt_n = r_cnt + CW'(1);
          end
        end
        default: begin
          w_state_n = ST_GUARD;
          w_cnt_n   = '0;
        end
      endcase

      if (w_state_n == ST_SCAN) begin
        w_dig_sel_n = ~(NUM_DIGITS'(1) << w_idx_n);
        w_hex_n     = w_active_n[w_idx_n];
        w_blank_n   = lzb && (w_idx_n != '0);
        for (int j = 0; j < NUM_DIGITS; j++) begin
          if ((IW'(j) >= w_idx_n) && (w_active_n[j] != 4'd0)) begin
            w_blank_n = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_GUARD;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_active   <= '0;
      r_pending  <= '0;
      r_wr_ready <= 1'b1;
      hex        <= 4'd0;
      blank      <= 1'b1;
      dig_sel    <= '1;
      frame_done <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_cnt      <= w_cnt_n;
      r_idx      <= w_idx_n;
      r_active   <= w_active_n;
      r_pending  <= w_pending_n;
      r_wr_ready <= w_wr_ready_n;
      hex        <= w_hex_n;
      blank      <= w_blank_n;
      dig_sel    <= w_dig_sel_n;
      frame_done <= w_frame_done_n;
    end
  end

endmodule
`default_nettype wire
